// File: rtl/nn_layer_mac.sv
// nn_layer_mac: one fully-connected neural-network layer built around a
// single signed multiply-accumulate unit.
//
// Operation:
//   - Weights are streamed in row-major order while the block is idle.
//     Neuron j, input i is held at index j*N_IN+i. Weights persist until
//     they are reloaded.
//   - An input vector of N_IN elements is then streamed in.
//   - The block performs N_IN*N_OUT MAC cycles.
//   - It then presents N_OUT activated results on consecutive cycles.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset (control state only)
//   in_valid_w  weight beat present on weight
//   weight      signed fixed-point weight (DATA_W bits, FRAC_W fractional)
//   in_valid_x  input beat present on data_x
//   data_x      signed fixed-point input element, index 0 first
//   act_mode    0 linear, 1 ReLU, 2 leaky (v>>>3), 3 linear; captured on x beat 0
//   busy        high while computing or presenting results
//   out_valid   out carries a neuron result
//   out         neuron result, neuron 0 first; 0 when out_valid is low
module nn_layer_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int N_IN   = 4,
    parameter int N_OUT  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_w,
    input  logic [DATA_W-1:0] weight,
    input  logic              in_valid_x,
    input  logic [DATA_W-1:0] data_x,
    input  logic [1:0]        act_mode,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out
);

    localparam int NW  = N_IN * N_OUT;
    localparam int AW  = 2 * DATA_W + $clog2(N_IN);
    localparam int WCW = $clog2(NW);
    localparam int XCW = $clog2(N_IN);
    localparam int OCW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

    localparam logic signed [AW-1:0] SAT_HI = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_LO = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

    state_t r_state, w_state_nxt;

    logic signed [DATA_W-1:0] r_wmem [NW];
    logic signed [DATA_W-1:0] r_xbuf [N_IN];
    logic signed [DATA_W-1:0] r_res  [N_OUT];

    logic [WCW-1:0]       r_wcnt;
    logic [XCW-1:0]       r_xcnt;
    logic [WCW-1:0]       r_widx;
    logic [XCW-1:0]       r_ci;
    logic [OCW-1:0]       r_cj;
    logic [OCW-1:0]       r_oj;
    logic                 r_w_ok;
    logic                 r_start;
    logic [1:0]           r_mode;
    logic signed [AW-1:0] r_acc;

    logic                       w_accept;
    logic                       w_wbeat;
    logic                       w_xbeat;
    logic                       w_ci_last;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [AW-1:0]       w_prod_ext;
    logic signed [AW-1:0]       w_sum;
    logic signed [AW-1:0]       w_shift;
    logic signed [DATA_W-1:0]   w_res;

    function automatic logic signed [DATA_W-1:0] sat_f(input logic signed [AW-1:0] v);
        if (v > SAT_HI)      sat_f = SAT_HI[DATA_W-1:0];
        else if (v < SAT_LO) sat_f = SAT_LO[DATA_W-1:0];
        else                 sat_f = v[DATA_W-1:0];
    endfunction

    function automatic logic signed [DATA_W-1:0] act_f(input logic signed [DATA_W-1:0] v,
                                                       input logic [1:0] m);
        case (m)
            2'd1:    act_f = v[DATA_W-1] ? '0 : v;
            2'd2:    act_f = v[DATA_W-1] ? (v >>> 3) : v;
            default: act_f = v;
        endcase
    endfunction

    // r_start marks the one cycle between the last x beat and CALC.
    // Inputs stay locked out during that cycle as well as while busy.
    assign w_accept  = (r_state == S_IDLE) && !r_start;
    // A weight beat wins over a simultaneous x beat.
    assign w_wbeat   = w_accept && in_valid_w;
    assign w_xbeat   = w_accept && !in_valid_w && in_valid_x && r_w_ok;
    assign w_ci_last = (r_ci == XCW'(N_IN - 1));

    // MAC datapath: the result is formed from the running sum on a neuron's last input.
    assign w_prod     = r_wmem[r_widx] * r_xbuf[r_ci];
    assign w_prod_ext = {{(AW-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_sum      = r_acc + w_prod_ext;
    assign w_shift    = w_sum >>> FRAC_W;
    assign w_res      = act_f(sat_f(w_shift), r_mode);

    // Control: counters, flags and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_xcnt  <= '0;
            r_widx  <= '0;
            r_ci    <= '0;
            r_cj    <= '0;
            r_oj    <= '0;
            r_w_ok  <= 1'b0;
            r_start <= 1'b0;
            r_mode  <= 2'd0;
            r_acc   <= '0;
        end else begin
            r_start <= w_xbeat && (r_xcnt == XCW'(N_IN - 1));
            if (w_wbeat) begin
                if (r_wcnt == WCW'(NW - 1)) begin
                    r_wcnt <= '0;
                    r_w_ok <= 1'b1;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                    r_w_ok <= 1'b0;
                end
            end
            if (w_xbeat) begin
                if (r_xcnt == '0) r_mode <= act_mode;
                r_xcnt <= (r_xcnt == XCW'(N_IN - 1)) ? '0 : r_xcnt + 1'b1;
            end
            if (r_state == S_CALC) begin
                r_widx <= (r_widx == WCW'(NW - 1)) ? '0 : r_widx + 1'b1;
                if (w_ci_last) begin
                    r_ci  <= '0;
                    r_acc <= '0;
                    r_cj  <= (r_cj == OCW'(N_OUT - 1)) ? '0 : r_cj + 1'b1;
                end else begin
                    r_ci  <= r_ci + 1'b1;
                    r_acc <= w_sum;
                end
            end
            if (r_state == S_OUT) begin
                r_oj <= (r_oj == OCW'(N_OUT - 1)) ? '0 : r_oj + 1'b1;
            end
        end
    end

    // Storage: weights, input buffer and results (never reset)
    always_ff @(posedge clk) begin
        if (w_wbeat) r_wmem[r_wcnt] <= weight;
        if (w_xbeat) r_xbuf[r_xcnt] <= data_x;
        if ((r_state == S_CALC) && w_ci_last) r_res[r_cj] <= w_res;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_start) w_state_nxt = S_CALC;
            S_CALC:  if (w_ci_last && (r_cj == OCW'(N_OUT - 1))) w_state_nxt = S_OUT;
            S_OUT:   if (r_oj == OCW'(N_OUT - 1)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        out_valid = 1'b0;
        out       = '0;
        case (r_state)
            S_CALC: busy = 1'b1;
            S_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out       = r_res[r_oj];
            end
            default: ;
        endcase
    end

endmodule

// File: doc/nn_layer_mac.md
NN_LAYER_MAC -- requirements
Module: nn_layer_mac

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning signed two's-complement fixed-point width of weights, inputs and outputs.
REQ-002 SHALL have parameter FRAC_W, default 8, meaning fractional bits of every DATA_W value.
REQ-003 SHALL have parameter N_IN, default 4, meaning inputs per neuron (range 2..16).
REQ-004 SHALL have parameter N_OUT, default 3, meaning neurons in the layer (range 1..8).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; one clock, synchronous, active-high.
REQ-007 SHALL have port in_valid_w, input, 1, a weight beat is present on weight.
REQ-008 SHALL have port weight, input, DATA_W, weight value in row-major order (neuron j, input i at index j*N_IN+i).
REQ-009 SHALL have port in_valid_x, input, 1, a data beat is present on data_x.
REQ-010 SHALL have port data_x, input, DATA_W, input vector element, index 0 first.
REQ-011 SHALL have port act_mode, input, 2, activation: 0 linear, 1 ReLU, 2 leaky (x>>>3), 3 treated as linear.
REQ-012 SHALL have port busy, output, 1, high in CALC and OUT states.
REQ-013 SHALL have port out_valid, output, 1, out carries a neuron result.
REQ-014 SHALL have port out, output, DATA_W, neuron result, neuron 0 first.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, OUT; reset enters IDLE.
REQ-016 In IDLE, each cycle with in_valid_w high SHALL store weight at the weight counter index and increment it; gaps allowed; at N_IN*N_OUT beats the counter wraps to 0 and flag w_ok sets.
REQ-017 Weights SHALL persist across frames until overwritten; a new weight load clears w_ok until complete.
REQ-018 In IDLE with in_valid_w and in_valid_x both high, the weight beat SHALL be taken and the x beat ignored.
REQ-019 x beats while w_ok is low SHALL be ignored.
REQ-020 x beats SHALL fill a N_IN-entry buffer via counter with gaps allowed; act_mode sampled on x beat 0.
REQ-021 On the cycle after the N_IN-th x beat (edge T) the FSM SHALL enter CALC and stay exactly N_IN*N_OUT cycles, one signed DATA_W x DATA_W product accumulated per cycle.
REQ-022 Accumulator width SHALL be 2*DATA_W+clog2(N_IN); cleared at start of each neuron.
REQ-023 Each neuron result SHALL be acc >>> FRAC_W (arithmetic, floor), saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1], then activation applied, and stored in an N_OUT result buffer.
REQ-024 ReLU SHALL map negative to 0; leaky SHALL map negative v to v>>>3 (floor); non-negative passes.
REQ-025 After CALC the FSM SHALL enter OUT: out_valid high for exactly N_OUT consecutive cycles, first at cycle T+N_IN*N_OUT+1, then return to IDLE.
REQ-026 out SHALL be 0 whenever out_valid is low.
REQ-027 While busy, in_valid_w and in_valid_x SHALL be ignored and no stored state changed by them.
REQ-028 A new frame MAY begin loading x on the cycle after the last out_valid.

Reset
REQ-029 rst high at an edge SHALL force IDLE, out_valid=0, out=0, busy=0, both counters=0, w_ok=0, accumulator=0, at any state including mid-CALC or mid-OUT.
REQ-030 Weight and buffer storage contents need not be cleared; w_ok=0 makes them unusable until reloaded.

Verification (N_IN=4, N_OUT=3, DATA_W=16, FRAC_W=8)
REQ-031 Load 12 weights 0x0100, x=0x0100,0x0200,0x0300,0x0400, mode 0 -> out 0x0A00 x3, first out_valid 13 cycles after last x edge.
REQ-032 Weights 0xFF00, same x, mode 1 -> 0x0000 x3; mode 2 -> 0xFEC0 x3; mode 0 -> 0xF600 x3.
REQ-033 Weights 0x7FFF, x all 0x7FFF, mode 0 -> 0x7FFF x3 (saturation); weights 0x8000, x 0x7FFF -> 0x8000 x3.
REQ-034 Assert rst during CALC cycle 5 -> next cycle out_valid=0, busy=0; subsequent x frame without weight reload produces no out_valid.
REQ-035 Drive in_valid_x/in_valid_w with garbage while busy, and both valid simultaneously in IDLE -> results identical to REQ-031, x beat during dual-valid not counted.
REQ-036 Gapped loads (valid toggling every other cycle) -> results identical to REQ-031.
